// File: rtl/port_fifo_pkg.sv
// rtl/port_fifo_pkg.sv - shared bus addresses, status/control bit map and helpers for port_fifo
//
// Contents:
//   e_iaddr_dst / e_iaddr_src : bus destination/source addresses used by the COM port
//   PORT_FIFO_MAX_DEPTH       : largest supported FIFO depth
//   ST_*                      : bit positions inside the status byte
//   CTRL_*                    : bit positions inside the control byte
//   sat4()                    : clamp a count to a 4-bit nibble
package port_fifo_pkg;

  typedef enum logic [3:0] {
    COMA = 4'd11,
    COMD = 4'd12
  } e_iaddr_dst;

  typedef enum logic [7:0] {
    COMAR = 8'd34,
    COMDR = 8'd35
  } e_iaddr_src;

  localparam int PORT_FIFO_MAX_DEPTH = 16;

  localparam int ST_TXOVF   = 7;
  localparam int ST_RXUDF   = 6;
  localparam int ST_TXFULL  = 5;
  localparam int ST_RXEMPTY = 4;

  localparam int CTRL_FLUSH_TX = 0;
  localparam int CTRL_FLUSH_RX = 1;

  // A full 16-deep FIFO holds 16 words, which does not fit the status nibble.
  function automatic logic [3:0] sat4(input logic [4:0] c);
    return (c > 5'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/port_fifo_fifo_core.sv
// rtl/port_fifo_fifo_core.sv - first-word fall-through FIFO used for both port directions
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   push, din       : write request and data
//   pop             : read request; dout shows the head combinationally
//   flush           : discard all contents, overrides push and pop
//   full, empty     : registered-state flags
//   count           : occupancy 0..DEPTH
//   ovf_evt         : pulse, push refused because full with no pop
//   udf_evt         : pulse, pop requested while empty
module fifo_core #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             ovf_evt,
  output logic             udf_evt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | (pop & ~empty)) & ~flush;
  assign ovf_evt = push & full & ~(pop & ~empty) & ~flush;
  assign udf_evt = pop & empty & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/port_fifo.sv
// rtl/port_fifo.sv - buffered COM bus port with TX and RX FIFOs, control and status
//
// Optional feature macro: PORT_FIFO_IRQ_EN (adds the irq output and IRQ_THRESH)
//
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   instr_dst           : bus destination; ADDR_TX pushes TX, ADDR_CTRL flushes
//   instr_src           : bus source; ADDR_RX pops RX, ADDR_STAT reads status
//   bus_din             : bus write data
//   bus_dout, bus_oe    : read data and drive enable for the shared data_buf
//   tx_data, tx_valid   : TX head towards the peripheral
//   tx_ready            : peripheral takes tx_data
//   rx_data, rx_valid   : word from the peripheral
//   rx_ready            : RX has room
//   irq                 : RX level / sticky flag interrupt (PORT_FIFO_IRQ_EN only)
module port_fifo
  import port_fifo_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter logic [3:0] ADDR_TX   = COMD,
  parameter logic [3:0] ADDR_CTRL = COMA,
  parameter logic [7:0] ADDR_RX   = COMDR,
  parameter logic [7:0] ADDR_STAT = COMAR
`ifdef PORT_FIFO_IRQ_EN
  , parameter int       IRQ_THRESH = DEPTH / 2
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instr_dst,
  input  logic [7:0] instr_src,
  input  logic [7:0] bus_din,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
`ifdef PORT_FIFO_IRQ_EN
  , output logic     irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          rd_rx, rd_stat, wr_tx, wr_ctrl;
  logic          flush_tx, flush_rx;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] rx_count;
  logic [7:0]    rx_head;
  logic          tx_ovf_evt, rx_udf_evt;
  logic          tx_ovf, rx_udf;
  logic [7:0]    status;
  logic [CW-1:0] unused_tx_count;
  logic          unused_tx_udf, unused_rx_ovf;

  assign rd_rx    = (instr_src == ADDR_RX);
  assign rd_stat  = (instr_src == ADDR_STAT);
  assign wr_tx    = (instr_dst == ADDR_TX);
  assign wr_ctrl  = (instr_dst == ADDR_CTRL);
  assign flush_tx = wr_ctrl & bus_din[CTRL_FLUSH_TX];
  assign flush_rx = wr_ctrl & bus_din[CTRL_FLUSH_RX];

  assign tx_valid = ~tx_empty;
  // rx_ready uses the registered full flag, so a bus pop never refills RX in the same cycle.
  assign rx_ready = rst & ~rx_full;

  fifo_core #(.WIDTH(8), .DEPTH(DEPTH)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_tx),
    .pop     (tx_valid & tx_ready),
    .flush   (flush_tx),
    .din     (bus_din),
    .dout    (tx_data),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (unused_tx_count),
    .ovf_evt (tx_ovf_evt),
    .udf_evt (unused_tx_udf)
  );

  fifo_core #(.WIDTH(8), .DEPTH(DEPTH)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_valid & rx_ready),
    .pop     (rd_rx),
    .flush   (flush_rx),
    .din     (rx_data),
    .dout    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count),
    .ovf_evt (unused_rx_ovf),
    .udf_evt (rx_udf_evt)
  );

  always_comb begin
    status             = '0;
    status[ST_TXOVF]   = tx_ovf;
    status[ST_RXUDF]   = rx_udf;
    status[ST_TXFULL]  = tx_full;
    status[ST_RXEMPTY] = rx_empty;
    status[3:0]        = sat4(5'(rx_count));
  end

  assign bus_oe = rst & (rd_rx | rd_stat);

  always_comb begin
    bus_dout = 8'h00;
    if (rst) begin
      if (rd_rx && !rx_empty) bus_dout = rx_head;
      else if (rd_stat)       bus_dout = status;
    end
  end

  // A new event in the same cycle as a status read keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      tx_ovf <= (tx_ovf & ~rd_stat) | tx_ovf_evt;
      rx_udf <= (rx_udf & ~rd_stat) | rx_udf_evt;
    end
  end

`ifdef PORT_FIFO_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (rx_count >= CW'(IRQ_THRESH)) | tx_ovf | rx_udf;
  end
`endif

endmodule

// File: tb/tb_port_fifo.sv
// tb/tb_port_fifo.sv - directed self-checking bench for port_fifo (DEPTH=8)
module tb_port_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] instr_dst = 4'd0;
  logic [7:0] instr_src = 8'd0;
  logic [7:0] bus_din = 8'd0;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
`ifdef PORT_FIFO_IRQ_EN
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;

  port_fifo #(.DEPTH(8)
`ifdef PORT_FIFO_IRQ_EN
    , .IRQ_THRESH(4)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_dst (instr_dst),
    .instr_src (instr_src),
    .bus_din   (bus_din),
    .bus_dout  (bus_dout),
    .bus_oe    (bus_oe),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
`ifdef PORT_FIFO_IRQ_EN
    , .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] d);
    instr_dst = 4'd12;
    bus_din   = d;
    step();
    instr_dst = 4'd0;
  endtask

  task automatic rx_put(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] d);
    instr_dst = 4'd11;
    bus_din   = d;
    step();
    instr_dst = 4'd0;
  endtask

  task automatic rd(input logic [7:0] src, output logic [7:0] d, output logic oe);
    instr_src = src;
    #1;
    d  = bus_dout;
    oe = bus_oe;
    step();
    instr_src = 8'd0;
  endtask

  logic [7:0] d;
  logic       oe;

  initial begin
    // reset held low: all outputs quiet even with a status read on the bus
    instr_src = 8'd34;
    #2;
    chk("rst_oe", bus_oe, 1'b0);
    chk("rst_dout", bus_dout, 8'h00);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_rxr", rx_ready, 1'b0);
    step();
    rst = 1'b1;
    instr_src = 8'd0;
    #1;
    chk("rel_rxr", rx_ready, 1'b1);
    chk("rel_txv", tx_valid, 1'b0);

    // reset mid-stream after 3 TX pushes
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
    chk("pre_rst_txv", tx_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_txv", tx_valid, 1'b0);
    step();
    rst = 1'b1;
    #1;
    rd(8'd34, d, oe);
    chk("mid_rst_stat", d, 8'h10);
    chk("mid_rst_oe", oe, 1'b1);

    // TX delivery order
    push_tx(8'hA1); push_tx(8'hB2);
    chk("tx_valid", tx_valid, 1'b1);
    chk("tx_head", tx_data, 8'hA1);
    tx_ready = 1'b1;
    #1;
    chk("tx_d0", tx_data, 8'hA1);
    step();
    chk("tx_d1", tx_data, 8'hB2);
    chk("tx_v1", tx_valid, 1'b1);
    step();
    tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 1'b0);

    // TX overflow, sticky clear, full push with simultaneous pop
    for (int i = 0; i < 8; i++) push_tx(8'h40 + 8'(i));
    push_tx(8'hFF);
    rd(8'd34, d, oe);
    chk("ovf_stat", d, 8'hB0);
    rd(8'd34, d, oe);
    chk("ovf_clear", d, 8'h30);
    chk("ovf_head", tx_data, 8'h40);
    instr_dst = 4'd12;
    bus_din   = 8'hC9;
    tx_ready  = 1'b1;
    step();
    instr_dst = 4'd0;
    tx_ready  = 1'b0;
    rd(8'd34, d, oe);
    chk("full_pp_stat", d, 8'h30);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain", tx_data, (i == 7) ? 8'hC9 : 8'h41 + 8'(i));
      step();
    end
    tx_ready = 1'b0;
    chk("drain_empty", tx_valid, 1'b0);

    // RX fill, FWFT reads, underflow
    rx_put(8'h11); rx_put(8'h22); rx_put(8'h33);
    rd(8'd34, d, oe);
    chk("rx3_stat", d, 8'h03);
    rd(8'd35, d, oe); chk("rx_r0", d, 8'h11); chk("rx_oe0", oe, 1'b1);
    rd(8'd35, d, oe); chk("rx_r1", d, 8'h22);
    rd(8'd35, d, oe); chk("rx_r2", d, 8'h33);
    rd(8'd35, d, oe); chk("rx_udf_rd", d, 8'h00); chk("rx_udf_oe", oe, 1'b1);
    rd(8'd34, d, oe); chk("udf_stat", d, 8'h50);
    rd(8'd34, d, oe); chk("udf_clear", d, 8'h10);

    // idle source: no drive
    instr_src = 8'd99;
    #1;
    chk("idle_oe", bus_oe, 1'b0);
    chk("idle_dout", bus_dout, 8'h00);
    instr_src = 8'd0;

    // RX flush in the same cycle as a bus pop
    rx_put(8'h55); rx_put(8'h66);
    instr_dst = 4'd11;
    bus_din   = 8'h02;
    instr_src = 8'd35;
    #1;
    chk("flush_pop_dout", bus_dout, 8'h55);
    step();
    instr_dst = 4'd0;
    instr_src = 8'd0;
    rd(8'd34, d, oe);
    chk("flush_rx_stat", d, 8'h10);

    // RX full with bus pop: no same-cycle refill
    for (int i = 0; i < 8; i++) rx_put(8'h80 + 8'(i));
    chk("rx_full_rdy", rx_ready, 1'b0);
    rd(8'd34, d, oe);
    chk("rx_full_stat", d, 8'h08);
    instr_src = 8'd35;
    rx_valid  = 1'b1;
    rx_data   = 8'hEE;
    #1;
    chk("full_pop_rdy", rx_ready, 1'b0);
    chk("full_pop_dout", bus_dout, 8'h80);
    step();
    instr_src = 8'd0;
    rx_valid  = 1'b0;
    chk("after_pop_rdy", rx_ready, 1'b1);
    rd(8'd34, d, oe);
    chk("after_pop_stat", d, 8'h07);
    rd(8'd35, d, oe);
    chk("no_refill", d, 8'h81);

    // RX-only flush (upper bits ignored) with a peripheral write in the same cycle
    push_tx(8'hAB);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    ctrl(8'hFE);
    rx_valid = 1'b0;
    rd(8'd34, d, oe);
    chk("flush_rx_only", d, 8'h10);
    chk("tx_kept", tx_data, 8'hAB);
    chk("tx_kept_v", tx_valid, 1'b1);

    // TX flush with a simultaneous peripheral pop
    push_tx(8'hCD);
    tx_ready = 1'b1;
    ctrl(8'h01);
    tx_ready = 1'b0;
    chk("flush_tx_v", tx_valid, 1'b0);
    rd(8'd34, d, oe);
    chk("flush_tx_stat", d, 8'h10);

    // no bypass into an empty RX
    rx_valid  = 1'b1;
    rx_data   = 8'h99;
    instr_src = 8'd35;
    #1;
    chk("nobyp_dout", bus_dout, 8'h00);
    step();
    rx_valid  = 1'b0;
    instr_src = 8'd0;
    rd(8'd34, d, oe); chk("nobyp_stat", d, 8'h41);
    rd(8'd34, d, oe); chk("nobyp_clear", d, 8'h01);
    rd(8'd35, d, oe); chk("nobyp_word", d, 8'h99);

    // overflow during a status read: flag survives the read
    for (int i = 0; i < 8; i++) push_tx(8'h10 + 8'(i));
    instr_dst = 4'd12;
    bus_din   = 8'h5A;
    instr_src = 8'd34;
    #1;
    chk("race_stat", bus_dout, 8'h30);
    step();
    instr_dst = 4'd0;
    instr_src = 8'd0;
    rd(8'd34, d, oe);
    chk("race_keep", d, 8'hB0);
    ctrl(8'h03);
    rd(8'd34, d, oe);
    chk("both_flushed", d, 8'h10);

`ifdef PORT_FIFO_IRQ_EN
    step();
    chk("irq_idle", irq, 1'b0);
    rx_put(8'h01); rx_put(8'h02); rx_put(8'h03);
    step();
    chk("irq_below", irq, 1'b0);
    rx_put(8'h04);
    step();
    chk("irq_rise", irq, 1'b1);
    rd(8'd35, d, oe);
    step();
    chk("irq_fall", irq, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_fifo.md
Name: port_fifo

Overview:
- Buffered bus port for the 8-bit move-machine bus; successor to the single-register COM ports.
- Provides a TX FIFO (bus → peripheral) and an RX FIFO (peripheral → bus), each DEPTH deep.
- Exposes a control destination and a status source on the bus.
- Sits between the bus decode and a serial/COM peripheral; the top level wires bus_dout/bus_oe into the shared data_buf tristate.

Parameters:
- DEPTH, 8: entries per FIFO; power of two, 2..16.
- ADDR_TX, COMD (4'd12): destination address that pushes into TX.
- ADDR_CTRL, COMA (4'd11): destination address for control (flush) writes.
- ADDR_RX, COMDR (8'd35): source address that pops from RX.
- ADDR_STAT, COMAR (8'd34): source address that reads the status byte.
- IRQ_THRESH, DEPTH/2: RX level that raises irq (optional feature only).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- instr_dst  in  4  bus destination address (e_iaddr_dst).
- instr_src  in  8  bus source address (e_iaddr_src).
- bus_din  in  8  bus data as seen by writers.
- bus_dout  out  8  data this block drives when bus_oe=1.
- bus_oe  out  1  drive enable for the data_buf tristate.
- tx_data  out  8  TX FIFO head.
- tx_valid  out  1  TX not empty.
- tx_ready  in  1  peripheral accepts tx_data.
- rx_data  in  8  peripheral word to be stored.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  RX not full.
- irq  out  1  present only with PORT_FIFO_IRQ_EN.

Behaviour:
- Reset (rst=0, async):
  - Pointers, counts and sticky flags cleared.
  - bus_oe=0, bus_dout=0, tx_valid=0, rx_ready=0, irq=0 while rst is low.
  - After release: rx_ready=1, tx_valid=0.
- Bus push:
  - instr_dst==ADDR_TX pushes bus_din into TX at posedge.
  - If TX is full and tx_valid&tx_ready is not true in that cycle, the word is dropped and sticky tx_ovf is set.
  - Full with a simultaneous pop: the push is accepted and count is unchanged.
- Bus pop:
  - instr_src==ADDR_RX: bus_oe=1 combinationally and bus_dout = RX head (first-word fall-through, zero latency).
  - The pop happens at the posedge of that cycle.
  - RX empty: bus_dout=8'h00, no pointer change, sticky rx_udf set.
  - No bypass: a word entering an empty RX in the same cycle is not visible and still causes rx_udf.
- Status read:
  - instr_src==ADDR_STAT: bus_oe=1.
  - bus_dout = {tx_ovf, rx_udf, tx_full, rx_empty, rx_cnt_sat[3:0]}; rx_cnt_sat = min(rx_count, 15).
  - The read clears tx_ovf and rx_udf at posedge.
  - A flag event in the same cycle wins: the flag stays set.
- Control write:
  - instr_dst==ADDR_CTRL; bus_din[0] flushes TX, bus_din[1] flushes RX, at posedge.
  - Flush wins over a simultaneous push or pop on that FIFO; the discarded push sets no flag.
  - Bits [7:2] are ignored.
- Peripheral side:
  - tx_valid = !tx_empty; tx_data = TX head; transfer on tx_valid&tx_ready.
  - rx_ready = !rx_full; transfer on rx_valid&rx_ready.
  - RX full and bus pop in the same cycle: rx_ready stays 0 (registered-full view); no same-cycle refill.
- Bus outputs:
  - bus_oe=0 for any other instr_src.
  - bus_dout holds 0 when bus_oe=0.
- Pointers: log2(DEPTH)-bit, wrapping modulo DEPTH.
- Count: log2(DEPTH)+1 bits, range 0..DEPTH; full is count==DEPTH.
- Simultaneous push and pop on a non-empty, non-full FIFO: both occur, count unchanged.
- Bus and peripheral sides act independently in the same cycle.

Optional Feature:
- Macro: PORT_FIFO_IRQ_EN.
- When defined, the irq port exists and is registered: irq = (rx_count >= IRQ_THRESH) | tx_ovf | rx_udf, updated at posedge.
- irq clears when the condition clears, e.g. after a status read and draining.
- When undefined: no irq port, no irq logic, IRQ_THRESH unused.

Decomposition:
- oisc8_pkg gains:
  - PORT_FIFO_MAX_DEPTH = 16.
  - Status bit index constants: ST_TXOVF = 7, ST_RXUDF = 6, ST_TXFULL = 5, ST_RXEMPTY = 4.
  - Control bit constants: CTRL_FLUSH_TX = 0, CTRL_FLUSH_RX = 1.
- Address defaults use the existing e_iaddr_dst / e_iaddr_src enums.
- One sub-module: fifo_core (WIDTH, DEPTH).
  - Signals: push, pop, flush, din, dout (FWFT), full, empty, count, ovf_evt, udf_evt pulses.
  - Instantiated twice.
- port_fifo holds address decode, sticky flags, status mux and irq.

Test Plan:
- Reset with rst=0 mid-stream after 3 TX pushes → tx_valid=0, status reads 8'h10, RX count 0 after release.
- Push 8'hA1, 8'hB2 via ADDR_TX with tx_ready=0 → tx_valid=1, tx_data=A1; raise tx_ready for 2 cycles → A1 then B2 delivered, tx_valid=0.
- Fill TX with DEPTH=8 words, push a 9th (8'hFF) with tx_ready=0 → dropped; status bit7=1, tx_full=1.
  - Second status read → bit7=0.
  - Repeat the full push with tx_ready=1 → accepted, no ovf.
- Peripheral writes 8'h11, 8'h22, 8'h33 into RX → status low nibble 3; three ADDR_RX reads return 11, 22, 33 with bus_oe=1.
  - Fourth read → 8'h00, rx_udf=1.
- RX holds 2 words; flush RX (CTRL=8'h02) in the same cycle as an ADDR_RX read → rx_empty=1, count 0, no udf.
  - TX flush in the same cycle as a push → TX empty, no ovf.
- PORT_FIFO_IRQ_EN with IRQ_THRESH=4 → irq rises the cycle after the 4th RX word; one bus pop (count 3) → irq falls the next cycle.
